// File: rtl/minv_mdiv_seq_ctrl.sv
// Sequencer for the MINV_MDIV core: latches an operand set, streams it into the
// core's 16-bit load ports, kicks the core, waits for ready and reads both results back.
module minv_mdiv_seq_ctrl #(
    parameter int NWORDS  = 16,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_minv,
    input  logic [16*NWORDS-1:0]   a_in,
    input  logic [16*NWORDS-1:0]   b_in,
    input  logic [16*NWORDS-1:0]   p_in,
    output logic                   busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic                   flag_out,
    output logic [16*NWORDS-1:0]   x1_out,
    output logic [16*NWORDS-1:0]   x2_out,
    output logic [15:0]            datain,
    output logic                   loada,
    output logic                   loadp,
    output logic                   loadb,
    output logic                   minv_mdiv_en,
    output logic                   minv_mdiv,
    output logic                   outx1,
    output logic                   outx2,
    input  logic [15:0]            regx1out,
    input  logic [15:0]            regx2out,
    input  logic                   minv_mdiv_rdy,
    input  logic                   minv_mdiv_flag
);

    localparam int OPW = 16 * NWORDS;
    localparam int WIW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CW  = $clog2(NWORDS + RD_LAT + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_P,
        LOAD_B,
        KICK,
        WAIT,
        READ,
        FIN
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    wcnt_reg, wcnt_next;
    logic [TW-1:0]    tmo_reg, tmo_next;

    logic [OPW-1:0]   a_reg, b_reg, p_reg;
    logic             op_reg;
    logic [OPW-1:0]   x1_sh_reg, x2_sh_reg;
    logic             flag_sh_reg;
    logic [OPW-1:0]   x1_out_reg, x2_out_reg;
    logic             flag_out_reg, err_reg;

    logic             accept, rdy_hit, capture, fin_ok, fin_to;
    logic [WIW-1:0]   wsel;

    logic [15:0]      a_words [NWORDS];
    logic [15:0]      p_words [NWORDS];
    logic [15:0]      b_words [NWORDS];

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
        assign a_words[gi] = a_reg[16*gi +: 16];
        assign p_words[gi] = p_reg[16*gi +: 16];
        assign b_words[gi] = b_reg[16*gi +: 16];
    end

    // The word counter doubles as the load word index; only its low bits address a word.
    assign wsel = wcnt_reg[WIW-1:0];

    always_comb begin
        state_next   = state_reg;
        wcnt_next    = wcnt_reg;
        tmo_next     = tmo_reg;
        busy         = (state_reg != IDLE);
        done         = 1'b0;
        datain       = 16'h0000;
        loada        = 1'b0;
        loadp        = 1'b0;
        loadb        = 1'b0;
        minv_mdiv_en = 1'b0;
        minv_mdiv    = (state_reg != IDLE) ? op_reg : 1'b0;
        outx1        = 1'b0;
        outx2        = 1'b0;
        accept       = 1'b0;
        rdy_hit      = 1'b0;
        capture      = 1'b0;
        fin_ok       = 1'b0;
        fin_to       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = LOAD_A;
                    wcnt_next  = '0;
                end
            end
            LOAD_A: begin
                loada  = 1'b1;
                datain = a_words[wsel];
                if (wcnt_reg == CW'(NWORDS - 1)) begin
                    state_next = LOAD_P;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt_reg + CW'(1);
                end
            end
            LOAD_P: begin
                loadp  = 1'b1;
                datain = p_words[wsel];
                if (wcnt_reg == CW'(NWORDS - 1)) begin
                    state_next = op_reg ? KICK : LOAD_B;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt_reg + CW'(1);
                end
            end
            LOAD_B: begin
                loadb  = 1'b1;
                datain = b_words[wsel];
                if (wcnt_reg == CW'(NWORDS - 1)) begin
                    state_next = KICK;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt_reg + CW'(1);
                end
            end
            KICK: begin
                minv_mdiv_en = 1'b1;
                tmo_next     = '0;
                state_next   = WAIT;
            end
            WAIT: begin
                tmo_next = tmo_reg + TW'(1);
                // A ready arriving on the expiry cycle still counts as success.
                if (minv_mdiv_rdy) begin
                    rdy_hit    = 1'b1;
                    wcnt_next  = '0;
                    state_next = READ;
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    fin_to     = 1'b1;
                    state_next = FIN;
                end
            end
            READ: begin
                outx1   = (wcnt_reg < CW'(NWORDS));
                outx2   = (wcnt_reg < CW'(NWORDS));
                capture = (wcnt_reg >= CW'(RD_LAT));
                if (wcnt_reg == CW'(NWORDS + RD_LAT - 1)) begin
                    fin_ok     = 1'b1;
                    wcnt_next  = '0;
                    state_next = FIN;
                end else begin
                    wcnt_next = wcnt_reg + CW'(1);
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wcnt_reg     <= '0;
            tmo_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            p_reg        <= '0;
            op_reg       <= 1'b0;
            x1_sh_reg    <= '0;
            x2_sh_reg    <= '0;
            flag_sh_reg  <= 1'b0;
            x1_out_reg   <= '0;
            x2_out_reg   <= '0;
            flag_out_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            tmo_reg   <= tmo_next;

            if (accept) begin
                a_reg   <= a_in;
                b_reg   <= b_in;
                p_reg   <= p_in;
                op_reg  <= op_minv;
                err_reg <= 1'b0;
            end

            if (rdy_hit) begin
                flag_sh_reg <= minv_mdiv_flag;
            end

            // Words arrive low first, so shifting in at the top leaves word 0 at the bottom.
            if (capture) begin
                x1_sh_reg <= {regx1out, x1_sh_reg[OPW-1:16]};
                x2_sh_reg <= {regx2out, x2_sh_reg[OPW-1:16]};
            end

            if (fin_ok) begin
                x1_out_reg   <= {regx1out, x1_sh_reg[OPW-1:16]};
                x2_out_reg   <= {regx2out, x2_sh_reg[OPW-1:16]};
                flag_out_reg <= flag_sh_reg;
                err_reg      <= 1'b0;
            end

            if (fin_to) begin
                x1_out_reg   <= '0;
                x2_out_reg   <= '0;
                flag_out_reg <= 1'b0;
                err_reg      <= 1'b1;
            end
        end
    end

    assign x1_out      = x1_out_reg;
    assign x2_out      = x2_out_reg;
    assign flag_out    = flag_out_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_minv_mdiv_seq_ctrl.sv
// Bench for minv_mdiv_seq_ctrl: behavioural MINV_MDIV core, a timeline model of the
// sequencer checked every cycle, and literal expectations for the directed cases.
module tb_minv_mdiv_seq_ctrl;

    localparam int L   = 16;
    localparam int RDL = 1;
    localparam int TMO = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op_minv = 1'b0;
    logic [255:0] a_in = '0, b_in = '0, p_in = '0;
    logic         busy, done, err_timeout, flag_out;
    logic [255:0] x1_out, x2_out;
    logic [15:0]  datain;
    logic         loada, loadp, loadb, minv_mdiv_en, minv_mdiv, outx1, outx2;
    logic [15:0]  regx1out, regx2out;
    logic         minv_mdiv_rdy, minv_mdiv_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minv_mdiv_seq_ctrl #(.NWORDS(L), .RD_LAT(RDL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .op_minv(op_minv),
        .a_in(a_in), .b_in(b_in), .p_in(p_in),
        .busy(busy), .done(done), .err_timeout(err_timeout), .flag_out(flag_out),
        .x1_out(x1_out), .x2_out(x2_out), .datain(datain),
        .loada(loada), .loadp(loadp), .loadb(loadb),
        .minv_mdiv_en(minv_mdiv_en), .minv_mdiv(minv_mdiv),
        .outx1(outx1), .outx2(outx2),
        .regx1out(regx1out), .regx2out(regx2out),
        .minv_mdiv_rdy(minv_mdiv_rdy), .minv_mdiv_flag(minv_mdiv_flag)
    );

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y,
                                            input logic [255:0] m);
        logic [511:0] prod;
        prod = {256'd0, x} * {256'd0, y};
        prod = prod % {256'd0, m};
        return prod[255:0];
    endfunction

    // Fermat inverse; every modulus used here is prime.
    function automatic logic [255:0] modinv(input logic [255:0] x, input logic [255:0] m);
        logic [255:0] e, r, base;
        e    = m - 256'd2;
        r    = 256'd1;
        base = mulmod(x, 256'd1, m);
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, base, m);
            base = mulmod(base, base, m);
        end
        return r;
    endfunction

    function automatic logic [255:0] core_x1(input logic op, input logic [255:0] a,
                                             input logic [255:0] b, input logic [255:0] p);
        logic [255:0] ia;
        ia = modinv(a, p);
        return op ? ia : mulmod(b, ia, p);
    endfunction

    // Behavioural core: rdy pulses core_delay cycles after the kick (0 = never),
    // result words appear one cycle after outx; x2 is defined as a ^ p.
    logic [255:0] core_a, core_b, core_p, core_res1, core_res2;
    int           core_rdy_cnt = 0;
    int           core_ridx = 0;
    int           core_delay = 0;
    logic         core_flag = 1'b0;
    logic         spur_rdy = 1'b0;
    logic [15:0]  rx1 = '0, rx2 = '0;

    assign minv_mdiv_rdy  = (core_rdy_cnt == 1) | spur_rdy;
    assign minv_mdiv_flag = core_flag;
    assign regx1out       = rx1;
    assign regx2out       = rx2;

    always @(posedge clk) begin
        if (rst) begin
            core_rdy_cnt <= 0;
            core_ridx    <= 0;
            rx1          <= '0;
            rx2          <= '0;
        end else begin
            if (loada) core_a <= {datain, core_a[255:16]};
            if (loadp) core_p <= {datain, core_p[255:16]};
            if (loadb) core_b <= {datain, core_b[255:16]};
            if (minv_mdiv_en) begin
                core_res1    <= core_x1(minv_mdiv, core_a, core_b, core_p);
                core_res2    <= core_a ^ core_p;
                core_rdy_cnt <= core_delay;
                core_ridx    <= 0;
            end else if (core_rdy_cnt > 0) begin
                core_rdy_cnt <= core_rdy_cnt - 1;
            end
            if (outx1) begin
                rx1       <= core_res1[16*core_ridx +: 16];
                rx2       <= core_res2[16*core_ridx +: 16];
                core_ridx <= core_ridx + 1;
            end
        end
    end

    // Timeline model: t counts cycles since the start was accepted.
    int           cyc = 0;
    bit           m_act = 0;
    int           m_s, m_rdy_t, m_fin_t;
    bit           m_op, m_to, m_flag_cap;
    logic [255:0] m_a, m_b, m_p, m_x1, m_x2;
    logic [255:0] h_x1 = '0, h_x2 = '0;
    bit           h_flag = 0, h_err = 0;
    logic [15:0]  cap_p [L];
    logic [15:0]  cap_b0 = '0;

    always @(negedge clk) begin
        int t, nb, ws;
        bit e_la, e_lp, e_lb, e_kick, e_ox, e_done;
        logic [15:0] e_din;
        logic [10:0] e_ctrl, a_ctrl;
        cyc++;
        t = 0; nb = 2; ws = 0;
        e_la = 0; e_lp = 0; e_lb = 0; e_kick = 0; e_ox = 0; e_done = 0;
        e_din = '0;
        if (rst) begin
            m_act = 0; h_x1 = '0; h_x2 = '0; h_flag = 0; h_err = 0;
        end else if (m_act) begin
            t  = cyc - m_s;
            nb = m_op ? 2 : 3;
            ws = nb * L + 2;
            e_la = (t >= 1) && (t <= L);
            e_lp = (t > L) && (t <= 2 * L);
            e_lb = (nb == 3) && (t > 2 * L) && (t <= 3 * L);
            if (e_la)      e_din = m_a[16*(t-1) +: 16];
            else if (e_lp) e_din = m_p[16*(t-L-1) +: 16];
            else if (e_lb) e_din = m_b[16*(t-2*L-1) +: 16];
            e_kick = (t == nb * L + 1);
            if (m_rdy_t >= 0) e_ox = (t > m_rdy_t) && (t <= m_rdy_t + L);
            e_done = (t == m_fin_t);
            if (e_done) begin
                h_x1   = m_to ? '0 : m_x1;
                h_x2   = m_to ? '0 : m_x2;
                h_flag = m_to ? 1'b0 : m_flag_cap;
                h_err  = m_to;
            end
        end

        e_ctrl = {m_act, e_done, h_err, h_flag, e_la, e_lp, e_lb, e_kick,
                  m_act & m_op, e_ox, e_ox};
        a_ctrl = {busy, done, err_timeout, flag_out, loada, loadp, loadb,
                  minv_mdiv_en, minv_mdiv, outx1, outx2};
        chk("ctrl", 256'(a_ctrl), 256'(e_ctrl));
        chk("datain", 256'(datain), 256'(e_din));
        chk("x1_out", x1_out, h_x1);
        chk("x2_out", x2_out, h_x2);

        if (!rst) begin
            if (m_act) begin
                if (e_lp) cap_p[t-L-1] = datain;
                if (e_lb && t == 2 * L + 1) cap_b0 = datain;
                if (t >= ws && m_rdy_t < 0 && !m_to) begin
                    if (minv_mdiv_rdy) begin
                        m_rdy_t    = t;
                        m_flag_cap = minv_mdiv_flag;
                        m_fin_t    = t + L + RDL + 1;
                    end else if (t - ws == TMO - 1) begin
                        m_to    = 1;
                        m_fin_t = t + 1;
                    end
                end
                if (e_done) m_act = 0;
            end else if (start) begin
                m_act   = 1;
                m_s     = cyc;
                m_op    = op_minv;
                m_a     = a_in;
                m_b     = b_in;
                m_p     = p_in;
                m_x1    = core_x1(op_minv, a_in, b_in, p_in);
                m_x2    = a_in ^ p_in;
                m_rdy_t = -1;
                m_fin_t = -1;
                m_to    = 0;
                h_err   = 0;
            end
        end
    end

    task automatic run_txn(input bit op, input logic [255:0] a, input logic [255:0] b,
                           input logic [255:0] p, input int delay, input bit flag,
                           input bit disturb, output int lat);
        lat        = -1;
        core_delay = delay;
        core_flag  = flag;
        @(posedge clk); #1;
        op_minv = op; a_in = a; b_in = b; p_in = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (disturb && k == 3) begin
                start = 1'b1; op_minv = ~op; a_in = a + 256'd1; spur_rdy = 1'b1;
            end
            if (disturb && k == 4) begin
                start = 1'b0; spur_rdy = 1'b0;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait got no done expected done within 5000 cycles");
        end
    endtask

    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] SM2_A =
        256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;

    initial begin
        int lat;
        logic [15:0] ew;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 256'({busy, done, err_timeout, flag_out, loada, loadp, loadb,
                               minv_mdiv_en, minv_mdiv, outx1, outx2}), 256'd0);
        chk("reset_x1", x1_out, 256'd0);
        chk("model_inv_5_11", modinv(256'd5, 256'd11), 256'd9);

        run_txn(1'b1, 256'd5, 256'd0, 256'd11, 20, 1'b1, 1'b0, lat);
        chk("inv_latency", 256'(lat), 256'd71);
        chk("inv_x1", x1_out, 256'd9);
        chk("inv_err", 256'(err_timeout), 256'd0);
        chk("inv_flag", 256'(flag_out), 256'd1);

        run_txn(1'b0, 256'd5, 256'd3, 256'd11, 20, 1'b0, 1'b0, lat);
        chk("div_latency", 256'(lat), 256'd87);
        chk("div_x1", x1_out, 256'd5);
        chk("div_loadb_w0", 256'(cap_b0), 256'h0003);

        run_txn(1'b1, SM2_A, 256'd0, SM2_P, 7, 1'b1, 1'b0, lat);
        chk("sm2_latency", 256'(lat), 256'd58);
        chk("sm2_inv", mulmod(x1_out, SM2_A, SM2_P), 256'd1);
        for (int i = 0; i < L; i++) begin
            ew = (i == 4 || i == 5) ? 16'h0000 : (i == 14) ? 16'hFFFE : 16'hFFFF;
            chk($sformatf("sm2_loadp_w%0d", i), 256'(cap_p[i]), 256'(ew));
        end

        run_txn(1'b1, 256'd5, 256'd0, 256'd11, 0, 1'b1, 1'b0, lat);
        chk("tmo_latency", 256'(lat), 256'd4130);
        chk("tmo_err", 256'(err_timeout), 256'd1);
        chk("tmo_x1", x1_out, 256'd0);

        run_txn(1'b1, 256'd7, 256'd0, 256'd13, 5, 1'b1, 1'b1, lat);
        chk("dist_latency", 256'(lat), 256'd56);
        chk("dist_x1", x1_out, 256'd2);
        chk("dist_err", 256'(err_timeout), 256'd0);

        core_delay = 0;
        @(posedge clk); #1;
        op_minv = 1'b0; a_in = 256'd5; b_in = 256'd3; p_in = 256'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #3;
        chk("rst_pre_busy", 256'(busy), 256'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_ctrl", 256'({busy, done, err_timeout, flag_out, loada, loadp, loadb,
                                   minv_mdiv_en, minv_mdiv, outx1, outx2}), 256'd0);
        chk("rst_async_datain", 256'(datain), 256'd0);
        chk("rst_async_x1", x1_out, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(1'b1, 256'd3, 256'd0, 256'd7, 3, 1'b0, 1'b0, lat);
        chk("post_rst_latency", 256'(lat), 256'd54);
        chk("post_rst_x1", x1_out, 256'd5);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
